// File: rtl/pong_game_ctrl_if.sv
// Game-control bundle: frame/start/paddle inputs toward the Pong sequencer and
// the sprite-control values it presents to the pixel renderer.
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic [9:0] paddle1_ypos;
    logic [9:0] paddle2_ypos;
    logic [9:0] square_xpos;
    logic [9:0] square_ypos;
    logic       sq_shown;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       game_over;
    logic [2:0] state;

    modport master (
        output frame_tick, start, paddle1_ypos, paddle2_ypos,
        input  square_xpos, square_ypos, sq_shown, score_p1, score_p2, game_over, state
    );

    modport slave (
        input  frame_tick, start, paddle1_ypos, paddle2_ypos,
        output square_xpos, square_ypos, sq_shown, score_p1, score_p2, game_over, state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong sequencer: ball motion, paddle/wall collision, scoring, serve
// timing and game-over; all state advances only on the frame tick.
module pong_game_ctrl #(
    parameter int H_VIDEO       = 640,
    parameter int V_VIDEO       = 480,
    parameter int SQUARE_WIDTH  = 16,
    parameter int PADDLE_WIDTH  = 12,
    parameter int PADDLE_HEIGHT = 96,
    parameter int PADDLE1_X     = 32,
    parameter int PADDLE2_X     = 596,
    parameter int BALL_SPEED    = 4,
    parameter int SERVE_FRAMES  = 60,
    parameter int WIN_SCORE     = 11
) (
    input  logic            clk_0,
    input  logic            rst,
    pong_game_ctrl_if.slave game_if
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // Geometry is compared in 11 bits so x+speed or paddle+height never wraps.
    localparam logic [10:0] CX_C     = 11'((H_VIDEO - SQUARE_WIDTH) / 2);
    localparam logic [10:0] CY_C     = 11'((V_VIDEO - SQUARE_WIDTH) / 2);
    localparam logic [10:0] X_MAX_C  = 11'(H_VIDEO - SQUARE_WIDTH);
    localparam logic [10:0] Y_MAX_C  = 11'(V_VIDEO - SQUARE_WIDTH);
    localparam logic [10:0] L_HIT_C  = 11'(PADDLE1_X + PADDLE_WIDTH);
    localparam logic [10:0] R_HIT_C  = 11'(PADDLE2_X - SQUARE_WIDTH);
    localparam logic [10:0] SPEED_C  = 11'(BALL_SPEED);
    localparam logic [10:0] SQ_C     = 11'(SQUARE_WIDTH);
    localparam logic [10:0] PH_C     = 11'(PADDLE_HEIGHT);
    localparam logic [9:0]  CX_P     = 10'(CX_C);
    localparam logic [9:0]  CY_P     = 10'(CY_C);
    localparam logic [7:0]  SERVE_C  = 8'(SERVE_FRAMES);
    localparam logic [3:0]  WIN_C    = 4'(WIN_SCORE);

    state_e      state_q;
    logic [9:0]  x_q;
    logic [9:0]  y_q;
    logic        dx_q;
    logic        dy_q;
    logic        serve_dy_q;
    logic        shown_q;
    logic [3:0]  score1_q;
    logic [3:0]  score2_q;
    logic        over_q;
    logic [7:0]  cnt_q;
    logic        p1_last_q;

    logic [10:0] x_s;
    logic [10:0] y_s;
    logic [10:0] pad1_s;
    logic [10:0] pad2_s;
    logic        ov1_s;
    logic        ov2_s;
    logic [7:0]  cnt_inc_s;
    logic        serve_done_s;
    logic        win_reached_s;

    logic [9:0]  x_d;
    logic [9:0]  y_d;
    logic        dx_d;
    logic        dy_d;
    logic        p1_pt_s;
    logic        p2_pt_s;

    // Scores saturate at the winning value.
    function automatic logic [3:0] score_inc(input logic [3:0] s);
        logic [3:0] r;
        if (s >= WIN_C) begin
            r = WIN_C;
        end else begin
            r = s + 4'd1;
        end
        return r;
    endfunction

    assign x_s           = {1'b0, x_q};
    assign y_s           = {1'b0, y_q};
    assign pad1_s        = {1'b0, game_if.paddle1_ypos};
    assign pad2_s        = {1'b0, game_if.paddle2_ypos};
    assign ov1_s         = (y_s + SQ_C >= pad1_s) && (y_s <= pad1_s + PH_C);
    assign ov2_s         = (y_s + SQ_C >= pad2_s) && (y_s <= pad2_s + PH_C);
    assign cnt_inc_s     = cnt_q + 8'd1;
    assign serve_done_s  = (cnt_inc_s == SERVE_C);
    assign win_reached_s = p1_last_q ? (score1_q == WIN_C) : (score2_q == WIN_C);

    // One PLAY frame step: vertical bounce first, then paddle hit, miss or glide.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        p1_pt_s = 1'b0;
        p2_pt_s = 1'b0;

        if (dy_q) begin
            if (y_s + SPEED_C >= Y_MAX_C) begin
                y_d  = 10'(Y_MAX_C);
                dy_d = 1'b0;
            end else begin
                y_d  = 10'(y_s + SPEED_C);
            end
        end else begin
            if (y_s < SPEED_C) begin
                y_d  = 10'd0;
                dy_d = 1'b1;
            end else begin
                y_d  = 10'(y_s - SPEED_C);
            end
        end

        if (!dx_q) begin
            if ((x_s >= L_HIT_C) && (x_s <= L_HIT_C + SPEED_C) && ov1_s) begin
                x_d  = 10'(L_HIT_C);
                dx_d = 1'b1;
            end else if (x_s < SPEED_C) begin
                x_d     = 10'd0;
                p2_pt_s = 1'b1;
            end else begin
                x_d = 10'(x_s - SPEED_C);
            end
        end else begin
            if ((x_s <= R_HIT_C) && (x_s + SPEED_C >= R_HIT_C) && ov2_s) begin
                x_d  = 10'(R_HIT_C);
                dx_d = 1'b0;
            end else if (x_s + SPEED_C > X_MAX_C) begin
                x_d     = 10'(X_MAX_C);
                p1_pt_s = 1'b1;
            end else begin
                x_d = 10'(x_s + SPEED_C);
            end
        end
    end

    // Game sequencer; every output is one of these registers.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            x_q        <= CX_P;
            y_q        <= CY_P;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            serve_dy_q <= 1'b1;
            shown_q    <= 1'b0;
            score1_q   <= 4'd0;
            score2_q   <= 4'd0;
            over_q     <= 1'b0;
            cnt_q      <= 8'd0;
            p1_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    // start beats a coincident tick: the tick is simply not looked at here.
                    if (game_if.start) begin
                        state_q    <= ST_SERVE;
                        x_q        <= CX_P;
                        y_q        <= CY_P;
                        dx_q       <= 1'b1;
                        dy_q       <= 1'b1;
                        serve_dy_q <= 1'b1;
                        shown_q    <= 1'b1;
                        score1_q   <= 4'd0;
                        score2_q   <= 4'd0;
                        over_q     <= 1'b0;
                        cnt_q      <= 8'd0;
                    end
                end
                ST_SERVE: begin
                    if (game_if.frame_tick) begin
                        if (serve_done_s) begin
                            state_q <= ST_PLAY;
                            cnt_q   <= 8'd0;
                            shown_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc_s;
                            if (cnt_inc_s[2:0] == 3'd0) begin
                                shown_q <= ~shown_q;
                            end
                        end
                    end
                end
                ST_PLAY: begin
                    if (game_if.frame_tick) begin
                        x_q  <= x_d;
                        y_q  <= y_d;
                        dx_q <= dx_d;
                        dy_q <= dy_d;
                        if (p1_pt_s) begin
                            state_q   <= ST_POINT;
                            score1_q  <= score_inc(score1_q);
                            p1_last_q <= 1'b1;
                            shown_q   <= 1'b0;
                            cnt_q     <= 8'd0;
                        end else if (p2_pt_s) begin
                            state_q   <= ST_POINT;
                            score2_q  <= score_inc(score2_q);
                            p1_last_q <= 1'b0;
                            shown_q   <= 1'b0;
                            cnt_q     <= 8'd0;
                        end
                    end
                end
                ST_POINT: begin
                    if (game_if.frame_tick) begin
                        if (serve_done_s) begin
                            cnt_q <= 8'd0;
                            if (win_reached_s) begin
                                state_q <= ST_OVER;
                                over_q  <= 1'b1;
                                shown_q <= 1'b0;
                            end else begin
                                // Serve toward whoever lost the point, alternating vertical direction.
                                state_q    <= ST_SERVE;
                                x_q        <= CX_P;
                                y_q        <= CY_P;
                                dx_q       <= p1_last_q;
                                dy_q       <= ~serve_dy_q;
                                serve_dy_q <= ~serve_dy_q;
                                shown_q    <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_inc_s;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    shown_q <= 1'b0;
                    over_q  <= 1'b0;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    assign game_if.square_xpos = x_q;
    assign game_if.square_ypos = y_q;
    assign game_if.sq_shown    = shown_q;
    assign game_if.score_p1    = score1_q;
    assign game_if.score_p2    = score2_q;
    assign game_if.game_over   = over_q;
    assign game_if.state       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: a rule-level game model checked every cycle, plus
// hand-computed positions/scores at key moments of a scripted match.
module tb_pong_game_ctrl;

    logic clk_0 = 1'b0;
    logic rst   = 1'b0;
    always #20 clk_0 = ~clk_0;

    pong_game_ctrl_if bus ();

    pong_game_ctrl dut (
        .clk_0   (clk_0),
        .rst     (rst),
        .game_if (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state: plain integers following the game rules.
    int m_state, m_x, m_y, m_dx, m_dy, m_shown, m_s1, m_s2, m_over;
    int m_n, m_serve_dy, m_last_p1;

    logic [9:0] p1_v = 10'd0;
    logic [9:0] p2_v = 10'd0;
    bit p1_track = 1'b1;
    bit p2_track = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit overlaps(input int y, input int pad);
        return (y + 16 >= pad) && (y <= pad + 96);
    endfunction

    task automatic award(input bit p1);
        if (p1) m_s1 = (m_s1 + 1 > 11) ? 11 : m_s1 + 1;
        else    m_s2 = (m_s2 + 1 > 11) ? 11 : m_s2 + 1;
        m_last_p1 = p1;
        m_state   = 3;
        m_n       = 0;
        m_shown   = 0;
    endtask

    task automatic play_frame(input int p1, input int p2);
        int nx, ny, ndx, ndy;
        bit p1_pt, p2_pt;
        ndx = m_dx; ndy = m_dy; p1_pt = 0; p2_pt = 0;
        if (m_dy == 1) begin
            if (m_y + 4 >= 464) begin ny = 464; ndy = 0; end
            else ny = m_y + 4;
        end else begin
            if (m_y < 4) begin ny = 0; ndy = 1; end
            else ny = m_y - 4;
        end
        if (m_dx == 0) begin
            if (m_x >= 44 && m_x <= 48 && overlaps(m_y, p1)) begin nx = 44; ndx = 1; end
            else if (m_x < 4) begin nx = 0; p2_pt = 1; end
            else nx = m_x - 4;
        end else begin
            if (m_x <= 580 && m_x + 4 >= 580 && overlaps(m_y, p2)) begin nx = 580; ndx = 0; end
            else if (m_x + 4 > 624) begin nx = 624; p1_pt = 1; end
            else nx = m_x + 4;
        end
        m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
        if (p1_pt) award(1'b1);
        else if (p2_pt) award(1'b0);
    endtask

    task automatic model_step(input logic r, input logic st, input logic ft, input int p1, input int p2);
        if (!r) begin
            m_state = 0; m_x = 312; m_y = 232; m_dx = 1; m_dy = 1; m_shown = 0;
            m_s1 = 0; m_s2 = 0; m_over = 0; m_n = 0; m_serve_dy = 1; m_last_p1 = 0;
        end else if ((m_state == 0 || m_state == 4) && st) begin
            m_state = 1; m_x = 312; m_y = 232; m_dx = 1; m_dy = 1; m_serve_dy = 1;
            m_s1 = 0; m_s2 = 0; m_over = 0; m_n = 0; m_shown = 1;
        end else if (ft) begin
            case (m_state)
                1: begin
                    m_n++;
                    if (m_n == 60) begin m_state = 2; m_n = 0; m_shown = 1; end
                    else m_shown = ((m_n / 8) % 2 == 0);
                end
                2: play_frame(p1, p2);
                3: begin
                    m_n++;
                    if (m_n == 60) begin
                        m_n = 0;
                        if ((m_last_p1 ? m_s1 : m_s2) == 11) begin
                            m_state = 4; m_over = 1; m_shown = 0;
                        end else begin
                            m_state = 1; m_x = 312; m_y = 232;
                            m_dx = m_last_p1 ? 1 : 0;
                            m_serve_dy = 1 - m_serve_dy;
                            m_dy = m_serve_dy;
                            m_shown = 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_0) begin
        if (chk_en) begin
            check("state",     32'(bus.state),       32'(m_state));
            check("xpos",      32'(bus.square_xpos), 32'(m_x));
            check("ypos",      32'(bus.square_ypos), 32'(m_y));
            check("sq_shown",  32'(bus.sq_shown),    32'(m_shown));
            check("score_p1",  32'(bus.score_p1),    32'(m_s1));
            check("score_p2",  32'(bus.score_p2),    32'(m_s2));
            check("game_over", 32'(bus.game_over),   32'(m_over));
        end
    end

    task automatic cycle(input logic r, input logic st, input logic ft);
        rst              = r;
        bus.start        = st;
        bus.frame_tick   = ft;
        bus.paddle1_ypos = p1_v;
        bus.paddle2_ypos = p2_v;
        @(posedge clk_0);
        model_step(r, st, ft, int'(p1_v), int'(p2_v));
        @(negedge clk_0);
    endtask

    function automatic logic [9:0] track(input int y);
        return (y >= 40) ? 10'(y - 40) : 10'd0;
    endfunction

    task automatic frame();
        p1_v = p1_track ? track(m_y) : 10'd900;
        p2_v = p2_track ? track(m_y) : 10'd900;
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        bus.start = 1'b0; bus.frame_tick = 1'b0;
        bus.paddle1_ypos = 10'd0; bus.paddle2_ypos = 10'd0;
        @(negedge clk_0);
        cycle(1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_x", 32'(bus.square_xpos), 32'd312);
        check("rst_y", 32'(bus.square_ypos), 32'd232);
        check("rst_shown", 32'(bus.sq_shown), 32'd0);
        check("rst_scores", 32'({bus.score_p1, bus.score_p2}), 32'd0);
        check("rst_over", 32'(bus.game_over), 32'd0);

        frames(2);
        check("idle_tick_ignored", 32'(bus.state), 32'd0);

        // start together with a tick: start wins, serve counter starts from zero.
        cycle(1'b1, 1'b1, 1'b1);
        check("serve_entry", 32'(bus.state), 32'd1);
        check("serve_shown", 32'(bus.sq_shown), 32'd1);
        frames(8);
        check("serve_blink_off", 32'(bus.sq_shown), 32'd0);
        frames(51);
        check("serve_59", 32'(bus.state), 32'd1);
        frame();
        check("play_entry", 32'(bus.state), 32'd2);
        check("play_x0", 32'(bus.square_xpos), 32'd312);
        check("play_y0", 32'(bus.square_ypos), 32'd232);
        check("play_shown", 32'(bus.sq_shown), 32'd1);
        frame();
        check("play_x1", 32'(bus.square_xpos), 32'd316);
        check("play_y1", 32'(bus.square_ypos), 32'd236);
        cycle(1'b1, 1'b1, 1'b0);
        check("start_in_play_x", 32'(bus.square_xpos), 32'd316);
        check("start_in_play_st", 32'(bus.state), 32'd2);
        frames(57);
        check("bottom_wall", 32'(bus.square_ypos), 32'd464);
        frame();
        check("bottom_rebound", 32'(bus.square_ypos), 32'd460);
        check("x_at_59", 32'(bus.square_xpos), 32'd548);
        frames(8);
        check("right_hit_x", 32'(bus.square_xpos), 32'd580);
        check("right_hit_y", 32'(bus.square_ypos), 32'd428);
        frames(134);
        check("left_hit_x", 32'(bus.square_xpos), 32'd44);
        check("left_hit_y", 32'(bus.square_ypos), 32'd104);

        // Left paddle steps away: ball comes back and P2 scores.
        p1_track = 1'b0;
        for (int i = 0; i < 1000 && m_state != 3; i++) frame();
        check("lmiss_state", 32'(bus.state), 32'd3);
        check("lmiss_x", 32'(bus.square_xpos), 32'd0);
        check("lmiss_p2", 32'(bus.score_p2), 32'd1);
        check("lmiss_shown", 32'(bus.sq_shown), 32'd0);
        frames(59);
        check("point_59", 32'(bus.state), 32'd3);
        frame();
        check("reserve_state", 32'(bus.state), 32'd1);
        check("reserve_x", 32'(bus.square_xpos), 32'd312);
        p1_track = 1'b1;
        frames(61);
        check("reserve_dir_x", 32'(bus.square_xpos), 32'd308);
        check("reserve_dir_y", 32'(bus.square_ypos), 32'd228);

        // P2 stays away until P1 reaches the winning score.
        p2_track = 1'b0;
        for (int i = 0; i < 6000 && m_state != 4; i++) frame();
        check("over_state", 32'(bus.state), 32'd4);
        check("over_p1", 32'(bus.score_p1), 32'd11);
        check("over_p2", 32'(bus.score_p2), 32'd1);
        check("over_flag", 32'(bus.game_over), 32'd1);
        frames(2);
        check("over_held", 32'(bus.score_p1), 32'd11);
        cycle(1'b1, 1'b1, 1'b0);
        check("restart_state", 32'(bus.state), 32'd1);
        check("restart_scores", 32'({bus.score_p1, bus.score_p2}), 32'd0);
        check("restart_over", 32'(bus.game_over), 32'd0);

        // P2 builds to 5, then reset lands mid-POINT.
        p1_track = 1'b0;
        p2_track = 1'b1;
        for (int i = 0; i < 4000 && !(m_state == 3 && m_s2 == 5); i++) frame();
        check("p2_five", 32'(bus.score_p2), 32'd5);
        frames(10);
        check("mid_point", 32'(bus.state), 32'd3);
        cycle(1'b0, 1'b0, 1'b1);
        check("mid_rst_state", 32'(bus.state), 32'd0);
        check("mid_rst_p2", 32'(bus.score_p2), 32'd0);
        check("mid_rst_x", 32'(bus.square_xpos), 32'd312);
        check("mid_rst_y", 32'(bus.square_ypos), 32'd232);
        check("mid_rst_shown", 32'(bus.sq_shown), 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        check("after_rst_start", 32'(bus.state), 32'd1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
